// File: rtl/gift_pipe_data_in_fifo.sv
// gift_pipe_data_in_fifo
//   Ingress buffer in front of pipeline stage 0 of the pipelined GIFT-128
//   datapath. The host writes plaintext/key pairs into a small FIFO. One
//   pair per cycle is issued into stage 0 whenever the pipeline advances.
//   Idle issue slots carry all-zero words, so no stale data enters the rounds.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   AW        pointer width, log2(DEPTH)
//
// Ports
//   inClk     clock; all state updates on the rising edge
//   inRst     synchronous active-high reset
//   inWr      host write strobe; one entry per cycle while high
//   inData    plaintext word
//   inKey     key word
//   inPipeEn  pipeline advance enable; a pop happens only while high
//   outFull   registered, occupancy == DEPTH
//   outEmpty  registered, occupancy == 0
//   outCount  registered occupancy, 0..DEPTH
//   outOvf    sticky overflow flag; cleared only by reset
//   outWr     registered issue strobe into stage 0
//   outData   registered plaintext to stage 0 (zero when outWr=0)
//   outKey    registered key to stage 0 (zero when outWr=0)
//   outSeq    (only with GIFT_PIPE_IN_SEQ_EN) 8-bit issue tag, zero when outWr=0
//
// Handshake semantics
//   inWr acts as a valid with no ready. The FIFO accepts the word if it is
//   not full, or if a pop happens in the same cycle. Otherwise the word is
//   dropped and outOvf latches. outWr acts as a valid with no back-pressure.
//   Stage 0 must consume the word in the cycle that outWr is high.
//
// Configuration
//   GIFT_PIPE_IN_SEQ_EN  adds the outSeq issue counter/tag.

module gift_pipe_data_in_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          inClk,
    input  logic          inRst,
    input  logic          inWr,
    input  logic [127:0]  inData,
    input  logic [127:0]  inKey,
    input  logic          inPipeEn,
    output logic          outFull,
    output logic          outEmpty,
    output logic [AW:0]   outCount,
    output logic          outOvf,
    output logic          outWr,
    output logic [127:0]  outData,
`ifdef GIFT_PIPE_IN_SEQ_EN
    output logic [127:0]  outKey,
    output logic [7:0]    outSeq
`else
    output logic [127:0]  outKey
`endif
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [127:0]  dataMem [DEPTH];
    logic [127:0]  keyMem  [DEPTH];
    logic [AW-1:0] wPtr;
    logic [AW-1:0] rPtr;
    logic [AW:0]   count;
    logic [AW:0]   countNext;
    logic          pop;
    logic          push;

    // A full FIFO can still take a write when a pop frees the slot in the same cycle.
    always_comb begin
        pop       = inPipeEn && (count != '0);
        push      = inWr && ((count != FULL_COUNT) || pop);
        countNext = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            wPtr     <= '0;
            rPtr     <= '0;
            count    <= '0;
            outFull  <= 1'b0;
            outEmpty <= 1'b1;
            outOvf   <= 1'b0;
            outWr    <= 1'b0;
            outData  <= '0;
            outKey   <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH == 2**AW.
            if (push) wPtr <= wPtr + AW'(1);
            if (pop)  rPtr <= rPtr + AW'(1);
            count    <= countNext;
            outFull  <= (countNext == FULL_COUNT);
            outEmpty <= (countNext == '0);
            if (inWr && !push) outOvf <= 1'b1;
            outWr    <= pop;
            outData  <= pop ? dataMem[rPtr] : '0;
            outKey   <= pop ? keyMem[rPtr]  : '0;
        end
    end

    assign outCount = count;

    // Storage is not reset. Array contents are don't-care after reset.
    always_ff @(posedge inClk) begin
        if (!inRst && push) begin
            dataMem[wPtr] <= inData;
            keyMem[wPtr]  <= inKey;
        end
    end

`ifdef GIFT_PIPE_IN_SEQ_EN
    logic [7:0] seqCnt;

    // The tag of an issued word is the count of pops before it, modulo 256.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            seqCnt <= '0;
            outSeq <= '0;
        end else begin
            if (pop) seqCnt <= seqCnt + 8'd1;
            outSeq <= pop ? seqCnt : 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_gift_pipe_data_in_fifo.sv
// Testbench for gift_pipe_data_in_fifo. The reference model is a queue of
// {data,key} pairs. Pop and push decisions come straight from the occupancy rules.

module tb_gift_pipe_data_in_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          inClk = 1'b0;
    logic          inRst;
    logic          inWr;
    logic [127:0]  inData;
    logic [127:0]  inKey;
    logic          inPipeEn;
    logic          outFull;
    logic          outEmpty;
    logic [AW:0]   outCount;
    logic          outOvf;
    logic          outWr;
    logic [127:0]  outData;
    logic [127:0]  outKey;
`ifdef GIFT_PIPE_IN_SEQ_EN
    logic [7:0]    outSeq;
`endif

    gift_pipe_data_in_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .inClk    (inClk),
        .inRst    (inRst),
        .inWr     (inWr),
        .inData   (inData),
        .inKey    (inKey),
        .inPipeEn (inPipeEn),
        .outFull  (outFull),
        .outEmpty (outEmpty),
        .outCount (outCount),
        .outOvf   (outOvf),
        .outWr    (outWr),
        .outData  (outData),
`ifdef GIFT_PIPE_IN_SEQ_EN
        .outKey   (outKey),
        .outSeq   (outSeq)
`else
        .outKey   (outKey)
`endif
    );

    // Clock.
    always #5 inClk = ~inClk;

    // Scoreboard state.
    int            nChecks = 0;
    int            nFails  = 0;
    logic [255:0]  modelQ[$];
    logic          expWr;
    logic [127:0]  expData;
    logic [127:0]  expKey;
    logic          expOvf;
    logic [AW:0]   expCount;
    logic          expFull;
    logic          expEmpty;
    logic [7:0]    expSeq;
    int            seqCnt;
    int            issued;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle, advance the model, and return #1 after the edge.
    task automatic driveCycle(input logic rst, input logic wr, input logic en,
                              input logic [127:0] d, input logic [127:0] k);
        logic [255:0] w;
        logic popM;
        logic pushM;
        inRst = rst; inWr = wr; inPipeEn = en; inData = d; inKey = k;
        if (rst) begin
            modelQ.delete();
            expWr = 1'b0; expData = '0; expKey = '0; expOvf = 1'b0;
            expSeq = 8'd0; seqCnt = 0;
        end else begin
            popM  = en && (modelQ.size() != 0);
            pushM = wr && ((modelQ.size() < DEPTH) || popM);
            if (popM) begin
                w = modelQ.pop_front();
                expWr = 1'b1; expData = w[255:128]; expKey = w[127:0];
                expSeq = 8'(seqCnt); seqCnt = (seqCnt + 1) % 256;
                issued++;
            end else begin
                expWr = 1'b0; expData = '0; expKey = '0; expSeq = 8'd0;
            end
            if (pushM) modelQ.push_back({d, k});
            else if (wr) expOvf = 1'b1;
        end
        expCount = (AW+1)'(modelQ.size());
        expFull  = (modelQ.size() == DEPTH);
        expEmpty = (modelQ.size() == 0);
        @(posedge inClk);
        #1;
    endtask

    task automatic test_reset();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        nChecks++;
        if ({outWr, outData, outKey} !== {1'b0, 128'd0, 128'd0}) begin
            nFails++;
            $display("FAIL reset_out: got wr=%0b data=%h key=%h, need zeros", outWr, outData, outKey);
        end
        nChecks++;
        if ({outCount, outFull, outEmpty, outOvf} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            nFails++;
            $display("FAIL reset_flags: got cnt=%0d full=%0b empty=%0b ovf=%0b, need 0/0/1/0",
                     outCount, outFull, outEmpty, outOvf);
        end
    endtask

    task automatic test_single();
        logic [127:0] d1;
        logic [127:0] k1;
        int wrSeen;
        d1 = 128'h0123456789abcdef0123456789abcdef;
        k1 = 128'hfedcba9876543210fedcba9876543210;
        wrSeen = 0;
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) driveCycle(1'b0, 1'b1, 1'b1, d1, k1);
            else        driveCycle(1'b0, 1'b0, 1'b1, '0, '0);
            if (outWr === 1'b1) wrSeen++;
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL single_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL single_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
            // The word must surface exactly two edges after the write.
            if (i == 1) begin
                nChecks++;
                if ({outWr, outData, outKey} !== {1'b1, d1, k1}) begin
                    nFails++;
                    $display("FAIL single_latency: got wr=%0b data=%h, need wr=1 data=%h", outWr, outData, d1);
                end
            end
        end
        nChecks++;
        if (wrSeen != 1) begin
            nFails++;
            $display("FAIL single_once: got %0d issues, need 1", wrSeen);
        end
    endtask

    task automatic test_overflow();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 11; i++) begin
            if (i < 5)       driveCycle(1'b0, 1'b1, 1'b0, rand128(), rand128());
            else if (i < 10) driveCycle(1'b0, 1'b0, 1'b1, '0, '0);
            else             driveCycle(1'b0, 1'b0, 1'b0, '0, '0);
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL ovf_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL ovf_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
            if (i == 4) begin
                nChecks++;
                if ({outFull, outCount, outOvf, outWr} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
                    nFails++;
                    $display("FAIL ovf_set: got full=%0b cnt=%0d ovf=%0b wr=%0b, need 1/4/1/0",
                             outFull, outCount, outOvf, outWr);
                end
            end
        end
    endtask

    task automatic test_full_write_pop();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 18; i++) begin
            if (i < 4)       driveCycle(1'b0, 1'b1, 1'b0, rand128(), rand128());
            else if (i < 13) driveCycle(1'b0, 1'b1, 1'b1, rand128(), rand128());
            else             driveCycle(1'b0, 1'b0, 1'b1, '0, '0);
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL fullpop_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL fullpop_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
        end
    endtask

    task automatic test_back_to_back();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 24; i++) begin
            if (i < 20) driveCycle(1'b0, 1'b1, 1'b1, 128'(i + 1), ~128'(i + 1));
            else        driveCycle(1'b0, 1'b0, 1'b1, '0, '0);
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL b2b_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL b2b_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
        end
    endtask

    task automatic test_reset_mid();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 11; i++) begin
            if (i < 3)       driveCycle(1'b0, 1'b1, 1'b0, rand128(), rand128());
            else if (i == 3) driveCycle(1'b1, 1'b0, 1'b1, '0, '0);
            else if (i == 7) driveCycle(1'b0, 1'b1, 1'b1, rand128(), rand128());
            else             driveCycle(1'b0, 1'b0, 1'b1, '0, '0);
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL rstmid_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL rstmid_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
        end
    endtask

    task automatic test_random();
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 300; i++) begin
            driveCycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 3) != 0, rand128(), rand128());
            nChecks++;
            if ({outWr, outData, outKey} !== {expWr, expData, expKey}) begin
                nFails++;
                $display("FAIL rand_out c%0d: got wr=%0b data=%h key=%h, need wr=%0b data=%h key=%h",
                         i, outWr, outData, outKey, expWr, expData, expKey);
            end
            nChecks++;
            if ({outCount, outFull, outEmpty, outOvf} !== {expCount, expFull, expEmpty, expOvf}) begin
                nFails++;
                $display("FAIL rand_flags c%0d: got %0d/%0b/%0b/%0b, need %0d/%0b/%0b/%0b",
                         i, outCount, outFull, outEmpty, outOvf, expCount, expFull, expEmpty, expOvf);
            end
        end
    endtask

`ifdef GIFT_PIPE_IN_SEQ_EN
    task automatic test_seq();
        int cyc;
        driveCycle(1'b1, 1'b0, 1'b0, '0, '0);
        issued = 0;
        cyc = 0;
        while (issued < 258 && cyc < 2000) begin
            driveCycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rand128(), rand128());
            cyc++;
            nChecks++;
            if ({outWr, outSeq, outData} !== {expWr, expSeq, expData}) begin
                nFails++;
                $display("FAIL seq c%0d: got wr=%0b seq=%0d data=%h, need wr=%0b seq=%0d data=%h",
                         cyc, outWr, outSeq, outData, expWr, expSeq, expData);
            end
        end
        nChecks++;
        if (issued < 258) begin
            nFails++;
            $display("FAIL seq_budget: got %0d issues, need 258", issued);
        end
        nChecks++;
        if (expWr && (outSeq !== 8'd1)) begin
            nFails++;
            $display("FAIL seq_wrap: got last seq=%0d, need 1", outSeq);
        end
    endtask
`endif

    initial begin
        inRst = 1'b1; inWr = 1'b0; inPipeEn = 1'b0; inData = '0; inKey = '0;
        issued = 0; seqCnt = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_write_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef GIFT_PIPE_IN_SEQ_EN
        test_seq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
